// File: rtl/mul_share_seq.sv
// Purpose : round-robin sequencer that shares one external 16x16 multiplier
//           cell between two requesters and builds (A*B) mod 2^32 from three
//           partial products (lo*lo, lo*hi, hi*lo).
// Latency : accept in cycle T -> rspN_valid pulse in cycle T+4+MUL_LAT.
// Backpressure: reqN_ready is high only in IDLE for the granted requester;
//           one job in flight, responses are never backpressured.
// Ports   : clk/reset (async, active high); reqN_valid/reqN_a/reqN_b/reqN_ready
//           job inputs; rspN_valid/rsp_result job outputs; mul_a/mul_b/mul_en
//           drive the cell and mul_p returns its product MUL_LAT cycles later.
module mul_share_seq #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_result,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  output logic        mul_en,
  input  logic [31:0] mul_p
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    ISSUE1 = 3'd2,
    ISSUE2 = 3'd3,
    DRAIN  = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t      state;
  logic        last;
  logic        owner;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] acc;
  logic [31:0] acc_nxt;
  logic [1:0]  issue_idx;

  // Tag pipe mirrors the cell pipeline: an entry emerges in the cycle its
  // product is on mul_p.
  logic        tag_vld [MUL_LAT];
  logic [1:0]  tag_idx [MUL_LAT];
  logic        tag_out_vld;
  logic [1:0]  tag_out_idx;

  logic        any_req;
  logic        grant;
  logic        accept;
  logic [31:0] sel_a;
  logic [31:0] sel_b;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    any_req = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant = ~last;
    else                          grant = req1_valid;
  end

  assign req0_ready = (state == IDLE) && any_req && !grant;
  assign req1_ready = (state == IDLE) && any_req &&  grant;
  assign accept     = (state == IDLE) && any_req;
  assign sel_a      = grant ? req1_a : req0_a;
  assign sel_b      = grant ? req1_b : req0_b;

  assign tag_out_vld = tag_vld[MUL_LAT-1];
  assign tag_out_idx = tag_idx[MUL_LAT-1];

  // Index 0 seeds the accumulator; the cross terms only reach the upper half,
  // so only their low 16 bits matter.
  always_comb begin
    acc_nxt = acc;
    if (tag_out_vld) begin
      if (tag_out_idx == 2'd0) acc_nxt = mul_p;
      else                     acc_nxt = acc + {mul_p[15:0], 16'h0000};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        tag_vld[i] <= 1'b0;
        tag_idx[i] <= 2'd0;
      end
      acc <= 32'h0;
    end else begin
      for (int i = MUL_LAT-1; i > 0; i--) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end
      tag_vld[0] <= mul_en;
      tag_idx[0] <= issue_idx;
      acc        <= acc_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      owner      <= 1'b0;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      issue_idx  <= 2'd0;
      mul_en     <= 1'b0;
      mul_a      <= 16'h0;
      mul_b      <= 16'h0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= 32'h0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            a_q       <= sel_a;
            b_q       <= sel_b;
            owner     <= grant;
            last      <= grant;
            mul_en    <= 1'b1;
            mul_a     <= sel_a[15:0];
            mul_b     <= sel_b[15:0];
            issue_idx <= 2'd0;
            state     <= ISSUE0;
          end
        end
        ISSUE0: begin
          mul_a     <= a_q[15:0];
          mul_b     <= b_q[31:16];
          issue_idx <= 2'd1;
          state     <= ISSUE1;
        end
        ISSUE1: begin
          mul_a     <= a_q[31:16];
          mul_b     <= b_q[15:0];
          issue_idx <= 2'd2;
          state     <= ISSUE2;
        end
        ISSUE2: begin
          mul_en    <= 1'b0;
          mul_a     <= 16'h0;
          mul_b     <= 16'h0;
          issue_idx <= 2'd0;
          state     <= DRAIN;
        end
        DRAIN: begin
          // Result is taken from acc_nxt so the final partial product lands
          // in the same edge that enters RESP.
          if (tag_out_vld && tag_out_idx == 2'd2) begin
            rsp_result <= acc_nxt;
            rsp0_valid <= ~owner;
            rsp1_valid <=  owner;
            state      <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_seq.sv
module tb_mul_share_seq;

  localparam int L1 = 1;
  localparam int L3 = 3;

  logic clk;
  logic reset;

  // instance with MUL_LAT = 1
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid, mul_en;
  logic [31:0] rsp_result, mul_p;
  logic [15:0] mul_a, mul_b;

  // instance with MUL_LAT = 3
  logic        e_req0_valid, e_req1_valid, e_req0_ready, e_req1_ready;
  logic [31:0] e_req0_a, e_req0_b, e_req1_a, e_req1_b;
  logic        e_rsp0_valid, e_rsp1_valid, e_mul_en;
  logic [31:0] e_rsp_result, e_mul_p;
  logic [15:0] e_mul_a, e_mul_b;

  mul_share_seq #(.MUL_LAT(L1)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_result(rsp_result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_en(mul_en), .mul_p(mul_p)
  );

  mul_share_seq #(.MUL_LAT(L3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req0_valid(e_req0_valid), .req0_a(e_req0_a), .req0_b(e_req0_b), .req0_ready(e_req0_ready),
    .req1_valid(e_req1_valid), .req1_a(e_req1_a), .req1_b(e_req1_b), .req1_ready(e_req1_ready),
    .rsp0_valid(e_rsp0_valid), .rsp1_valid(e_rsp1_valid), .rsp_result(e_rsp_result),
    .mul_a(e_mul_a), .mul_b(e_mul_b), .mul_en(e_mul_en), .mul_p(e_mul_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Multiplier cell models; idle cycles load random junk so a product consumed
  // in the wrong cycle shows up as a wrong result.
  logic [31:0] p1 [L1];
  logic [31:0] p3 [L3];
  always @(posedge clk) begin
    for (int i = L1-1; i > 0; i--) p1[i] <= p1[i-1];
    p1[0] <= mul_en ? ({16'h0, mul_a} * {16'h0, mul_b}) : $urandom;
    for (int i = L3-1; i > 0; i--) p3[i] <= p3[i-1];
    p3[0] <= e_mul_en ? ({16'h0, e_mul_a} * {16'h0, e_mul_b}) : $urandom;
  end
  assign mul_p   = p1[L1-1];
  assign e_mul_p = p3[L3-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fail_timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  // Scoreboard: entry pushed at acceptance, popped at the response pulse.
  typedef struct {
    logic        owner;
    int          due;
    logic [31:0] result;
  } exp_t;
  exp_t exp_q[$];
  logic acc_owner_q[$];
  int   acc_cyc_q[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (req0_ready || req1_ready)
        chk("ready_exclusive", {31'h0, req0_ready & req1_ready}, 32'h0);
      if (req0_valid && req0_ready) begin
        exp_q.push_back('{1'b0, cyc + 4 + L1, req0_a * req0_b});
        acc_owner_q.push_back(1'b0);
        acc_cyc_q.push_back(cyc);
      end
      if (req1_valid && req1_ready) begin
        exp_q.push_back('{1'b1, cyc + 4 + L1, req1_a * req1_b});
        acc_owner_q.push_back(1'b1);
        acc_cyc_q.push_back(cyc);
      end
      if (rsp0_valid || rsp1_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_rsp observed=rsp0:%0b,rsp1:%0b expected=none", rsp0_valid, rsp1_valid);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_both", {31'h0, rsp0_valid & rsp1_valid}, 32'h0);
          chk("rsp_owner", {31'h0, rsp1_valid}, {31'h0, e.owner});
          chk("rsp_result", rsp_result, e.result);
          chk("rsp_cycle", cyc, e.due);
        end
      end
    end
  end

  function automatic logic rdy(input int w);
    return (w == 1) ? req1_ready : req0_ready;
  endfunction

  // Drive a job to u_dut and hold valid until it is accepted.
  task automatic send(input int who, input logic [31:0] a, input logic [31:0] b);
    logic got;
    got = 1'b0;
    if (who == 1) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else          begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rdy(who)) begin got = 1'b1; break; end
    end
    if (!got) fail_timeout("send_accept");
    @(posedge clk); #1;
    if (who == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin done = 1'b1; break; end
    end
    if (!done) fail_timeout("wait_drain");
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic got;
    int   t0;
    reset = 1'b1;
    req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    e_req0_valid = 0; e_req1_valid = 0; e_req0_a = 0; e_req0_b = 0; e_req1_a = 0; e_req1_b = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rsp0", {31'h0, rsp0_valid}, 32'h0);
    chk("rst_rsp1", {31'h0, rsp1_valid}, 32'h0);
    chk("rst_result", rsp_result, 32'h0);
    chk("rst_mul_en", {31'h0, mul_en}, 32'h0);
    chk("rst_mul_a", {16'h0, mul_a}, 32'h0);
    chk("rst_mul_b", {16'h0, mul_b}, 32'h0);
    chk("rst_ready0", {31'h0, req0_ready}, 32'h0);
    chk("rst_ready1", {31'h0, req1_ready}, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;

    // Single job: issue sequence and operand pairs, then the response
    send(0, 32'h00010002, 32'h00030004);
    @(negedge clk);
    chk("iss0_en", {31'h0, mul_en}, 32'h1);
    chk("iss0_ab", {mul_a, mul_b}, 32'h0002_0004);
    @(negedge clk);
    chk("iss1_en", {31'h0, mul_en}, 32'h1);
    chk("iss1_ab", {mul_a, mul_b}, 32'h0002_0003);
    @(negedge clk);
    chk("iss2_en", {31'h0, mul_en}, 32'h1);
    chk("iss2_ab", {mul_a, mul_b}, 32'h0001_0004);
    @(negedge clk);
    chk("drain_en", {31'h0, mul_en}, 32'h0);
    chk("drain_ab", {mul_a, mul_b}, 32'h0);
    @(negedge clk);
    chk("single_rsp0", {31'h0, rsp0_valid}, 32'h1);
    chk("single_result", rsp_result, 32'h000A0008);
    @(negedge clk);
    chk("rsp_pulse_once", {31'h0, rsp0_valid}, 32'h0);
    chk("result_held", rsp_result, 32'h000A0008);
    wait_drain();

    // Wrap-around cases
    send(1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_drain();
    chk("wrap_ones", rsp_result, 32'h00000001);
    send(1, 32'h00010000, 32'h00010000);
    wait_drain();
    chk("wrap_zero", rsp_result, 32'h00000000);

    // Arbitration from reset: both held valid, expect 0,1,0,1 back-to-back
    do_reset();
    acc_owner_q.delete();
    acc_cyc_q.delete();
    req0_a = 32'h00000011; req0_b = 32'h00000022; req0_valid = 1'b1;
    req1_a = 32'h00050003; req1_b = 32'h00070009; req1_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (acc_owner_q.size() >= 4) begin got = 1'b1; break; end
      // Change the operands of whoever was just accepted; the DUT must ignore it.
      if (acc_owner_q.size() > 0 && acc_cyc_q[acc_cyc_q.size()-1] == cyc - 1) begin
        if (acc_owner_q[acc_owner_q.size()-1]) begin req1_a = req1_a + 32'h01230457; req1_b = ~req1_b; end
        else                                   begin req0_a = req0_a * 32'd3 + 32'd7; req0_b = req0_b ^ 32'hA5A50000; end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (!got) fail_timeout("arb_accepts");
    else begin
      for (int k = 0; k < 4; k++) begin
        chk("arb_order", {31'h0, acc_owner_q[k]}, k % 2);
        if (k > 0) chk("arb_spacing", acc_cyc_q[k] - acc_cyc_q[k-1], 5 + L1);
      end
    end
    wait_drain();

    // Busy: req1 raised 2 cycles after req0 acceptance
    send(0, 32'hDEAD0001, 32'h0000BEEF);
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_a = 32'h00001234; req1_b = 32'h00005678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("busy_ready1_low", {31'h0, req1_ready}, 32'h0);
    end
    @(negedge clk);
    chk("busy_ready1_after_resp", {31'h0, req1_ready}, 32'h1);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_drain();

    // Reset mid-job: assert at T+3 for 2 cycles
    send(0, 32'h0000FFFF, 32'h00000003);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_mul_en", {31'h0, mul_en}, 32'h0);
    chk("mid_rst_mul_ab", {mul_a, mul_b}, 32'h0);
    chk("mid_rst_rsp", {30'h0, rsp1_valid, rsp0_valid}, 32'h0);
    chk("mid_rst_result", rsp_result, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", {30'h0, rsp1_valid, rsp0_valid}, 32'h0);
    end
    @(posedge clk); #1;
    send(0, 32'h87654321, 32'h0F0F0F0F);
    wait_drain();

    // MUL_LAT = 3 instance
    e_req0_valid = 1'b1; e_req0_a = 32'h12345678; e_req0_b = 32'h9ABCDEF0;
    got = 1'b0;
    t0 = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (e_req0_ready) begin got = 1'b1; t0 = cyc; break; end
    end
    @(posedge clk); #1 e_req0_valid = 1'b0;
    if (!got) fail_timeout("lat3_accept");
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (e_rsp0_valid || e_rsp1_valid) begin got = 1'b1; break; end
    end
    if (!got) fail_timeout("lat3_rsp");
    else begin
      chk("lat3_cycle", cyc, t0 + 7);
      chk("lat3_owner", {30'h0, e_rsp1_valid, e_rsp0_valid}, 32'h1);
      chk("lat3_result", e_rsp_result, 32'h242D2080);
    end

    chk("sb_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
